// File: rtl/rst_seq.sv
// rst_seq: staged reset release sequencer.
//
// After the asynchronous reset RST_n is released, three active-low domain
// resets are released in order (bit 0, then bit 1, then bit 2) with
// programmable spacing. Once all three are released, sys_ready is raised.
// An optional synchronous soft reset puts every stage back into reset for a
// programmable time, then replays the full release sequence.
//
// Parameters:
//   HOLD_CYCLES  cycles from reset deassertion to stage-0 release (1..65535)
//   STAGE_GAP    cycles between successive stage releases          (1..65535)
//   SOFT_CYCLES  cycles all stages stay in reset after a soft reset (1..65535)
//
// Ports:
//   clk           system clock, rising edge
//   RST_n         asynchronous active-low reset
//   soft_rst_req  synchronous soft-reset request, acted on only in RUN
//   stage_rst_n   per-domain active-low resets, released bit 0 -> bit 2
//   sys_ready     high once all three stages are released
//   rst_cause     0: last sequence followed RST_n, 1: it followed a soft reset
//
// Build option:
//   RST_SEQ_SOFT_RST_EN  when defined, soft_rst_req triggers a soft reset
//                        from RUN. When undefined, soft_rst_req is ignored,
//                        the soft state is unreachable and rst_cause is 0.
//
// All outputs come straight from flops; nothing is combinational from inputs.

module rst_seq #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SOFT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       soft_rst_req,
  output logic [2:0] stage_rst_n,
  output logic       sys_ready,
  output logic       rst_cause
);

  typedef enum logic [2:0] {
    StHold = 3'd0,
    StRel0 = 3'd1,
    StRel1 = 3'd2,
    StRun  = 3'd3,
    StSoft = 3'd4
  } state_e;

  // Terminal counts: a state with N cycles leaves on the edge where the
  // counter (which starts at 0 on entry) equals N-1.
  localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GapLast  = 16'(STAGE_GAP - 1);
  localparam logic [15:0] SoftLast = 16'(SOFT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  stage_q, stage_d;
  logic        ready_q, ready_d;
  logic        cause_q, cause_d;

`ifndef RST_SEQ_SOFT_RST_EN
  // The request port stays on the interface but has no effect in this build.
  logic unused_soft_rst_req;
  assign unused_soft_rst_req = soft_rst_req;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    ready_d = ready_q;
    cause_d = cause_q;

    unique case (state_q)
      StHold: begin
        stage_d = 3'b000;
        ready_d = 1'b0;
        if (cnt_q == HoldLast) begin
          state_d = StRel0;
          cnt_d   = '0;
          stage_d = 3'b001;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StRel0: begin
        if (cnt_q == GapLast) begin
          state_d = StRel1;
          cnt_d   = '0;
          stage_d = 3'b011;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StRel1: begin
        if (cnt_q == GapLast) begin
          state_d = StRun;
          cnt_d   = '0;
          stage_d = 3'b111;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StRun: begin
        stage_d = 3'b111;
        ready_d = 1'b1;
        cnt_d   = '0;
`ifdef RST_SEQ_SOFT_RST_EN
        // Only RUN reacts to the request; elsewhere it is dropped, not queued.
        if (soft_rst_req) begin
          state_d = StSoft;
          stage_d = 3'b000;
          ready_d = 1'b0;
          cause_d = 1'b1;
        end
`endif
      end

      StSoft: begin
        stage_d = 3'b000;
        ready_d = 1'b0;
        if (cnt_q == SoftLast) begin
          state_d = StHold;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StHold;
        cnt_d   = '0;
        stage_d = 3'b000;
        ready_d = 1'b0;
      end
    endcase

`ifndef RST_SEQ_SOFT_RST_EN
    cause_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= StHold;
      cnt_q   <= '0;
      stage_q <= 3'b000;
      ready_q <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign stage_rst_n = stage_q;
  assign sys_ready   = ready_q;
  assign rst_cause   = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a default-parameter instance plus a fast
// instance (HOLD_CYCLES=1, STAGE_GAP=1). Soft-reset expectations follow the
// RST_SEQ_SOFT_RST_EN build option.

module tb_rst_seq;

  logic       clk = 1'b0;
  logic       RST_n;
  logic       soft_rst_req;
  logic       soft_fast;
  logic [2:0] stage_rst_n;
  logic       sys_ready;
  logic       rst_cause;
  logic [2:0] stage_fast;
  logic       ready_fast;
  logic       cause_fast;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rst_seq dut (
    .clk          (clk),
    .RST_n        (RST_n),
    .soft_rst_req (soft_rst_req),
    .stage_rst_n  (stage_rst_n),
    .sys_ready    (sys_ready),
    .rst_cause    (rst_cause)
  );

  rst_seq #(
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1),
    .SOFT_CYCLES (1)
  ) dut_fast (
    .clk          (clk),
    .RST_n        (RST_n),
    .soft_rst_req (soft_fast),
    .stage_rst_n  (stage_fast),
    .sys_ready    (ready_fast),
    .rst_cause    (cause_fast)
  );

  // Expected stage vector e edges into a release sequence.
  function automatic logic [2:0] exp_stage(input int e, input int hold, input int gap);
    exp_stage = {e >= hold + 2 * gap, e >= hold + gap, e >= hold};
  endfunction

  task automatic test_reset();
    RST_n        = 1'b0;
    soft_rst_req = 1'b0;
    soft_fast    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stage_rst_n !== 3'b000) begin
      errors++;
      $display("FAIL reset_stage got %b want 000", stage_rst_n);
    end
    checks++;
    if (sys_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", sys_ready);
    end
    checks++;
    if (rst_cause !== 1'b0) begin
      errors++;
      $display("FAIL reset_cause got %b want 0", rst_cause);
    end
    checks++;
    if (stage_fast !== 3'b000 || ready_fast !== 1'b0 || cause_fast !== 1'b0) begin
      errors++;
      $display("FAIL reset_fast got %b/%b/%b want 000/0/0", stage_fast, ready_fast, cause_fast);
    end
  endtask

  // Walks 26 edges of a release sequence starting at the first HOLD edge.
  // pulse_edge: soft request is raised after that edge (sampled on the next).
  task automatic run_seq(input int pulse_edge, input logic exp_cause, input bit chk_fast,
                         input string tag);
    logic [2:0] want;
    for (int e = 1; e <= 26; e++) begin
      @(posedge clk);
      #1;
      want = exp_stage(e, 16, 4);
      checks++;
      if (stage_rst_n !== want) begin
        errors++;
        $display("FAIL %s_stage edge %0d got %b want %b", tag, e, stage_rst_n, want);
      end
      checks++;
      if (sys_ready !== (e >= 24)) begin
        errors++;
        $display("FAIL %s_ready edge %0d got %b want %b", tag, e, sys_ready, e >= 24);
      end
      checks++;
      if (rst_cause !== exp_cause) begin
        errors++;
        $display("FAIL %s_cause edge %0d got %b want %b", tag, e, rst_cause, exp_cause);
      end
      checks++;
      if (!(stage_rst_n inside {3'b000, 3'b001, 3'b011, 3'b111})) begin
        errors++;
        $display("FAIL %s_order edge %0d got %b want monotonic", tag, e, stage_rst_n);
      end
      if (chk_fast) begin
        want = exp_stage(e, 1, 1);
        checks++;
        if (stage_fast !== want || ready_fast !== (e >= 3)) begin
          errors++;
          $display("FAIL %s_fast edge %0d got %b/%b want %b/%b", tag, e, stage_fast,
                   ready_fast, want, e >= 3);
        end
        checks++;
        if (!(stage_fast inside {3'b000, 3'b001, 3'b011, 3'b111})) begin
          errors++;
          $display("FAIL %s_fast_order edge %0d got %b want monotonic", tag, e, stage_fast);
        end
      end
      soft_rst_req = (e == pulse_edge);
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_power_up();
    @(negedge clk);
    RST_n = 1'b1;
    run_seq(0, 1'b0, 1'b1, "power_up");
  endtask

  task automatic test_rst_abort();
    @(negedge clk);
    RST_n = 1'b0;
    @(negedge clk);
    RST_n = 1'b1;
    repeat (18) @(posedge clk);
    #1;
    checks++;
    if (stage_rst_n !== 3'b001) begin
      errors++;
      $display("FAIL abort_pre_stage got %b want 001", stage_rst_n);
    end
    #2;
    RST_n = 1'b0;
    #1;
    // Still before the next rising edge: reset must have acted without a clock.
    checks++;
    if (stage_rst_n !== 3'b000 || sys_ready !== 1'b0 || rst_cause !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got %b/%b/%b want 000/0/0", stage_rst_n, sys_ready, rst_cause);
    end
    checks++;
    if (stage_fast !== 3'b000 || ready_fast !== 1'b0) begin
      errors++;
      $display("FAIL abort_async_fast got %b/%b want 000/0", stage_fast, ready_fast);
    end
    @(negedge clk);
    RST_n = 1'b1;
    // Pulse lands on edge 18, inside REL0, and must be ignored.
    run_seq(17, 1'b0, 1'b1, "abort_recover");
  endtask

  task automatic test_soft();
    soft_rst_req = 1'b1;
`ifdef RST_SEQ_SOFT_RST_EN
    @(posedge clk);
    #1;
    soft_rst_req = 1'b0;
    checks++;
    if (stage_rst_n !== 3'b000 || sys_ready !== 1'b0 || rst_cause !== 1'b1) begin
      errors++;
      $display("FAIL soft_entry got %b/%b/%b want 000/0/1", stage_rst_n, sys_ready, rst_cause);
    end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (stage_rst_n !== 3'b000 || sys_ready !== 1'b0 || rst_cause !== 1'b1) begin
        errors++;
        $display("FAIL soft_hold k %0d got %b/%b/%b want 000/0/1", k, stage_rst_n, sys_ready,
                 rst_cause);
      end
      soft_rst_req = (k == 3);
    end
    soft_rst_req = 1'b0;
    run_seq(0, 1'b1, 1'b0, "soft_recover");
`else
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (stage_rst_n !== 3'b111 || sys_ready !== 1'b1 || rst_cause !== 1'b0) begin
        errors++;
        $display("FAIL soft_ignored k %0d got %b/%b/%b want 111/1/0", k, stage_rst_n,
                 sys_ready, rst_cause);
      end
    end
    soft_rst_req = 1'b0;
`endif
  endtask

  // Request held high: one soft sequence per return to RUN.
  task automatic test_soft_held();
`ifdef RST_SEQ_SOFT_RST_EN
    soft_rst_req = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (e == 1 || e == 34) begin
        checks++;
        if (stage_rst_n !== 3'b000 || sys_ready !== 1'b0 || rst_cause !== 1'b1) begin
          errors++;
          $display("FAIL held_reenter edge %0d got %b/%b/%b want 000/0/1", e, stage_rst_n,
                   sys_ready, rst_cause);
        end
      end
      if (e == 32) begin
        checks++;
        if (stage_rst_n !== 3'b011) begin
          errors++;
          $display("FAIL held_rel edge %0d got %b want 011", e, stage_rst_n);
        end
      end
      if (e == 33) begin
        checks++;
        if (stage_rst_n !== 3'b111 || sys_ready !== 1'b1) begin
          errors++;
          $display("FAIL held_run edge %0d got %b/%b want 111/1", e, stage_rst_n, sys_ready);
        end
      end
    end
    soft_rst_req = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_rst_abort();
    test_soft();
    test_soft_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
